// File: rtl/sw_led_ctrl.sv
// Switch-driven LED controller: synchronizes and debounces SW0, turns each accepted
// press into a one-cycle PRESS pulse, and steps an OFF -> ON -> BLINK mode cycle.
module sw_led_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_HALF = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW0,
  output logic       LED0,
  output logic [1:0] MODE,
  output logic       PRESS
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_ON    = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [1:0]    sync_reg;
  logic          sw_s;
  logic          sw_db;
  logic [DW-1:0] deb_cnt_reg;
  logic          accept;
  logic          press_reg;
  logic [1:0]    mode_reg;
  logic [1:0]    mode_next;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;

  // Two-flop synchronizer; sync_reg[1] is the only consumer-visible copy of SW0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], SW0};
    end
  end

  assign sw_s   = sync_reg[1];
  assign accept = (sw_s != sw_db) && (deb_cnt_reg == DEB_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_db       <= 1'b0;
      deb_cnt_reg <= '0;
      press_reg   <= 1'b0;
    end else begin
      press_reg <= accept & sw_s;
      if (sw_s == sw_db) begin
        deb_cnt_reg <= '0;
      end else if (accept) begin
        sw_db       <= sw_s;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    mode_next = mode_reg;
    case (mode_reg)
      ST_OFF:   if (press_reg) mode_next = ST_ON;
      ST_ON:    if (press_reg) mode_next = ST_BLINK;
      ST_BLINK: if (press_reg) mode_next = ST_OFF;
      default:  mode_next = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_reg <= ST_OFF;
    end else begin
      mode_reg <= mode_next;
    end
  end

  // Blink timer starts lit on entry and is parked at zero in every other mode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (mode_next == ST_BLINK) begin
      if (mode_reg != ST_BLINK) begin
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b1;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end else begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end
  end

  always_comb begin
    LED0 = 1'b0;
    case (mode_reg)
      ST_ON:    LED0 = 1'b1;
      ST_BLINK: LED0 = phase_reg;
      default:  LED0 = 1'b0;
    endcase
  end

  assign MODE  = mode_reg;
  assign PRESS = press_reg;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Bench for sw_led_ctrl: directed scenarios plus random switch activity, each cycle
// compared against a run-length/elapsed-time reference model.
module tb_sw_led_ctrl;

  localparam int DEB = 16;
  localparam int BH  = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SW0 = 1'b0;
  logic       LED0;
  logic [1:0] MODE;
  logic       PRESS;

  int checks = 0;
  int failures = 0;

  sw_led_ctrl #(.DEB_CYCLES(DEB), .BLINK_HALF(BH)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW0(SW0), .LED0(LED0), .MODE(MODE), .PRESS(PRESS)
  );

  always #5 CLK = ~CLK;

  // Reference model: SW0 seen two edges late; a level is accepted once it has
  // disagreed with the debounced level for DEB consecutive edges.
  bit sw_hist[$];
  bit mism[$];
  bit m_db;
  bit m_press;
  int m_mode;
  int m_blink_t;

  task automatic model_reset();
    sw_hist.delete();
    mism.delete();
    m_db = 1'b0;
    m_press = 1'b0;
    m_mode = 0;
    m_blink_t = 0;
  endtask

  task automatic model_step();
    bit sws_pre;
    int run;
    bit acc;
    int old_mode;
    sws_pre = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 1'b0;
    sw_hist.push_back(SW0);
    if (sw_hist.size() > 8) void'(sw_hist.pop_front());
    mism.push_back(sws_pre != m_db);
    if (mism.size() > DEB) void'(mism.pop_front());
    run = 0;
    for (int i = mism.size() - 1; i >= 0 && mism[i]; i--) run++;
    acc = (run >= DEB);
    old_mode = m_mode;
    if (m_press) m_mode = (m_mode + 1) % 3;
    if (m_mode == 2) m_blink_t = (old_mode == 2) ? m_blink_t + 1 : 0;
    else m_blink_t = 0;
    if (acc) begin
      m_db = sws_pre;
      mism.delete();
    end
    m_press = acc && sws_pre;
  endtask

  function automatic logic [3:0] exp_out();
    logic led;
    if (m_mode == 2) led = ((m_blink_t / BH) % 2) == 0;
    else led = (m_mode == 1);
    return {led, 2'(m_mode), m_press};
  endfunction

  task automatic tick(input logic v);
    SW0 = v;
    @(posedge CLK);
    if (RST_N) model_step();
    @(negedge CLK);
  endtask

  task automatic apply_reset(input logic lvl);
    RST_N = 1'b0;
    SW0 = lvl;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({LED0, MODE, PRESS} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got %b, expected 0000", {LED0, MODE, PRESS});
    end
    RST_N = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick(1'b0);
      checks++;
      if ({LED0, MODE, PRESS} !== exp_out()) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got %b, expected %b", n, {LED0, MODE, PRESS}, exp_out());
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    int presses;
    apply_reset(1'b0);
    repeat (3) tick(1'b0);
    presses = 0;
    for (int n = 1; n <= 70; n++) begin
      tick(1'b1);
      if (PRESS === 1'b1) presses++;
      checks++;
      if ({LED0, MODE, PRESS} !== exp_out()) begin
        failures++;
        $display("FAIL clean_press cyc %0d: got %b, expected %b", n, {LED0, MODE, PRESS}, exp_out());
      end
      if (n == 18) begin
        checks++;
        if (PRESS !== 1'b1) begin
          failures++;
          $display("FAIL press_latency: PRESS=%b after edge 18, expected 1", PRESS);
        end
      end
      if (n == 19) begin
        checks++;
        if ({LED0, MODE} !== 3'b101) begin
          failures++;
          $display("FAIL mode_latency: led/mode=%b after edge 19, expected 101", {LED0, MODE});
        end
      end
    end
    checks++;
    if (presses != 1) begin
      failures++;
      $display("FAIL held_single_press: got %0d presses, expected 1", presses);
    end
    $display("test_clean_press done presses=%0d", presses);
  endtask

  task automatic bounce_phase(input int len, input logic lvl_mode, input string tag,
                              output int presses);
    logic lvl;
    presses = 0;
    for (int i = 0; i < len; i++) begin
      lvl = lvl_mode ? 1'b1 : (((i / 3) % 2) == 0);
      tick(lvl);
      if (PRESS === 1'b1) presses++;
    end
    for (int i = 0; i < 25; i++) begin
      tick(1'b0);
      if (PRESS === 1'b1) presses++;
    end
    $display("bounce phase %s presses=%0d mode=%b", tag, presses, MODE);
  endtask

  task automatic test_bounce();
    int p;
    repeat (25) tick(1'b0);
    bounce_phase(40, 1'b0, "toggle", p);
    checks++;
    if (p != 0 || MODE !== 2'b01) begin
      failures++;
      $display("FAIL bounce_toggle: presses=%0d mode=%b, expected 0 and 01", p, MODE);
    end
    bounce_phase(15, 1'b1, "pulse15", p);
    checks++;
    if (p != 0 || MODE !== 2'b01) begin
      failures++;
      $display("FAIL bounce_pulse15: presses=%0d mode=%b, expected 0 and 01", p, MODE);
    end
    bounce_phase(20, 1'b1, "pulse20", p);
    checks++;
    if (p != 1 || MODE !== 2'b10) begin
      failures++;
      $display("FAIL bounce_pulse20: presses=%0d mode=%b, expected 1 and 10", p, MODE);
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_modes [3];
    exp_modes[0] = 2'b01;
    exp_modes[1] = 2'b10;
    exp_modes[2] = 2'b00;
    apply_reset(1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 40; n++) begin
        tick(n < 20);
        checks++;
        if ({LED0, MODE, PRESS} !== exp_out()) begin
          failures++;
          $display("FAIL mode_cycle p%0d cyc %0d: got %b, expected %b", p, n, {LED0, MODE, PRESS}, exp_out());
        end
      end
      checks++;
      if (MODE !== exp_modes[p] || (p != 1 && LED0 !== (p == 0))) begin
        failures++;
        $display("FAIL mode_step %0d: mode=%b led=%b, expected mode %b", p, MODE, LED0, exp_modes[p]);
      end
      $display("mode_cycle pair %0d mode=%b led=%b", p, MODE, LED0);
    end
  endtask

  task automatic test_blink();
    int toggles, highs, guard;
    logic prev;
    apply_reset(1'b0);
    for (int n = 0; n < 40; n++) tick(n < 20);
    guard = 0;
    while (MODE !== 2'b10 && guard < 40) begin
      tick(1'b1);
      guard++;
    end
    checks++;
    if (MODE !== 2'b10) begin
      failures++;
      $display("FAIL blink_entry: mode=%b after %0d cycles, expected 10", MODE, guard);
    end
    toggles = 0;
    highs = (LED0 === 1'b1) ? 1 : 0;
    prev = LED0;
    for (int n = 1; n < 48; n++) begin
      tick(n < 30);
      if (LED0 !== prev) toggles++;
      if (LED0 === 1'b1) highs++;
      prev = LED0;
      checks++;
      if ({LED0, MODE, PRESS} !== exp_out()) begin
        failures++;
        $display("FAIL blink cyc %0d: got %b, expected %b", n, {LED0, MODE, PRESS}, exp_out());
      end
    end
    checks++;
    if (toggles != 5 || highs != 24) begin
      failures++;
      $display("FAIL blink_period: toggles=%0d highs=%0d, expected 5 and 24", toggles, highs);
    end
    // Press lands mid-phase; the model checks LED0 drops with MODE.
    for (int n = 0; n < 45; n++) begin
      tick(n < 23);
      checks++;
      if ({LED0, MODE, PRESS} !== exp_out()) begin
        failures++;
        $display("FAIL blink_exit cyc %0d: got %b, expected %b", n, {LED0, MODE, PRESS}, exp_out());
      end
    end
    $display("test_blink done toggles=%0d highs=%0d mode=%b", toggles, highs, MODE);
  endtask

  task automatic test_reset_mid_cycle();
    apply_reset(1'b0);
    for (int n = 0; n < 40; n++) tick(n < 20);
    checks++;
    if (MODE !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset_mode: mode=%b, expected 01", MODE);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({LED0, MODE, PRESS} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got %b before clock edge, expected 0000", {LED0, MODE, PRESS});
    end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    $display("test_reset_mid_cycle done");
  endtask

  task automatic test_reset_debounce();
    int first;
    apply_reset(1'b0);
    repeat (10) tick(1'b1);
    apply_reset(1'b1);
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      tick(1'b1);
      if (PRESS === 1'b1 && first == 0) first = n;
      checks++;
      if ({LED0, MODE, PRESS} !== exp_out()) begin
        failures++;
        $display("FAIL reset_debounce cyc %0d: got %b, expected %b", n, {LED0, MODE, PRESS}, exp_out());
      end
    end
    checks++;
    if (first != 18) begin
      failures++;
      $display("FAIL reset_requalify: first PRESS at edge %0d, expected 18", first);
    end
    $display("test_reset_debounce done first_press=%0d", first);
  endtask

  task automatic test_random();
    logic lvl;
    int len;
    apply_reset(1'b0);
    for (int seg = 0; seg < 60; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int n = 0; n < len; n++) begin
        tick(lvl);
        checks++;
        if ({LED0, MODE, PRESS} !== exp_out()) begin
          failures++;
          $display("FAIL random seg %0d cyc %0d: got %b, expected %b", seg, n, {LED0, MODE, PRESS}, exp_out());
        end
      end
      $display("random seg %0d lvl=%b len=%0d mode=%b", seg, lvl, len, MODE);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_mode_cycle();
    test_blink();
    test_reset_mid_cycle();
    test_reset_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
